// File: rtl/chipi74ls259_pkg.sv
// chipi74ls259_pkg: mode encodings ({CLRn,En}) and latch width for the 74LS259 model.
package chipi74ls259_pkg;
    localparam int LATCH_BITS = 8;
    typedef logic [1:0] mode_t;
    localparam mode_t MODE_DEMUX = 2'b00;
    localparam mode_t MODE_CLEAR = 2'b01;
    localparam mode_t MODE_WRITE = 2'b10;
    localparam mode_t MODE_HOLD  = 2'b11;
endpackage

// File: rtl/chipi74ls259_cell.sv
// chipi74ls259_cell: one latch bit of the 74LS259, updated on the rising clock edge.
module chipi74ls259_cell
    import chipi74ls259_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  sel,
    input  logic  d,
    input  mode_t mode,
    output logic  q
);
    logic q_q;
    logic q_d;
    // An unknown mode falls through every ternary and propagates X rather than resolving.
    always_comb begin
        q_d = (mode == MODE_HOLD)  ? q_q :
              (mode == MODE_WRITE) ? (sel ? d : q_q) :
              (mode == MODE_DEMUX) ? (sel & d) : 1'b0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_q <= 1'b0;
        else     q_q <= q_d;
    end
    assign q = q_q;
endmodule

// File: rtl/chipi74ls259.sv
// chipi74ls259: clocked 8-bit addressable latch; CHIPI74LS259_READBACK_EN adds an 8-to-1 readback port.
module chipi74ls259
    import chipi74ls259_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic A0_1,
    input  logic A1_2,
    input  logic A2_3,
    input  logic D_13,
    input  logic En_14,
    input  logic CLRn_15,
`ifdef CHIPI74LS259_READBACK_EN
    input  logic RdA0,
    input  logic RdA1,
    input  logic RdA2,
    output logic Rd_Z,
`endif
    output logic Q0_4,
    output logic Q1_5,
    output logic Q2_6,
    output logic Q3_7,
    output logic Q4_9,
    output logic Q5_10,
    output logic Q6_11,
    output logic Q7_12
);
    logic [LATCH_BITS-1:0] sel;
    logic [LATCH_BITS-1:0] q;
    mode_t                 mode;
    assign mode = {CLRn_15, En_14};
    assign sel  = LATCH_BITS'(1) << {A2_3, A1_2, A0_1};
    for (genvar i = 0; i < LATCH_BITS; i++) begin : g_cell
        chipi74ls259_cell u_cell (
            .clk  (clk),
            .rst  (rst),
            .sel  (sel[i]),
            .d    (D_13),
            .mode (mode),
            .q    (q[i])
        );
    end
    assign {Q7_12, Q6_11, Q5_10, Q4_9, Q3_7, Q2_6, Q1_5, Q0_4} = q;
`ifdef CHIPI74LS259_READBACK_EN
    assign Rd_Z = q[{RdA2, RdA1, RdA0}];
`endif
endmodule

// File: tb/tb_chipi74ls259.sv
// tb_chipi74ls259: directed checks of write/hold/demux/clear/reset, plus readback when CHIPI74LS259_READBACK_EN is set.
module tb_chipi74ls259;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic A0_1 = 1'b0, A1_2 = 1'b0, A2_3 = 1'b0;
    logic D_13 = 1'b0, En_14 = 1'b1, CLRn_15 = 1'b1;
    logic Q0_4, Q1_5, Q2_6, Q3_7, Q4_9, Q5_10, Q6_11, Q7_12;
    logic [7:0] q;
    int n_cmp = 0;
    int n_bad = 0;
`ifdef CHIPI74LS259_READBACK_EN
    logic RdA0 = 1'b0, RdA1 = 1'b0, RdA2 = 1'b0;
    logic Rd_Z;
`endif

    chipi74ls259 dut (
        .clk     (clk),
        .rst     (rst),
        .A0_1    (A0_1),
        .A1_2    (A1_2),
        .A2_3    (A2_3),
        .D_13    (D_13),
        .En_14   (En_14),
        .CLRn_15 (CLRn_15),
`ifdef CHIPI74LS259_READBACK_EN
        .RdA0    (RdA0),
        .RdA1    (RdA1),
        .RdA2    (RdA2),
        .Rd_Z    (Rd_Z),
`endif
        .Q0_4    (Q0_4),
        .Q1_5    (Q1_5),
        .Q2_6    (Q2_6),
        .Q3_7    (Q3_7),
        .Q4_9    (Q4_9),
        .Q5_10   (Q5_10),
        .Q6_11   (Q6_11),
        .Q7_12   (Q7_12)
    );

    always #5 clk = ~clk;
    assign q = {Q7_12, Q6_11, Q5_10, Q4_9, Q3_7, Q2_6, Q1_5, Q0_4};

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic [2:0] a);
        {A2_3, A1_2, A0_1} = a;
    endtask

    task automatic load(input logic [7:0] p);
        CLRn_15 = 1'b1;
        En_14   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_a(3'(i));
            D_13 = p[i];
            tick();
        end
        En_14 = 1'b1;
    endtask

    initial begin
        tick();
        tick();
        chk("reset_idle", q, 8'h00);
        rst = 1'b0;
        tick();
        chk("post_reset_hold", q, 8'h00);

        En_14 = 1'b0;
        D_13  = 1'b1;
        for (int a = 0; a < 8; a++) begin
            set_a(3'(a));
            tick();
            chk($sformatf("write_sweep_%0d", a), q, 8'((16'(1) << (a + 1)) - 1));
        end
        D_13 = 1'b0;
        set_a(3'd5);
        tick();
        chk("write_a5_zero", q, 8'hDF);

        En_14 = 1'b1;
        #2 rst = 1'b1;
        #1 chk("async_reset", q, 8'h00);
`ifdef CHIPI74LS259_READBACK_EN
        chk("async_reset_rd", {7'd0, Rd_Z}, 8'h00);
`endif
        En_14 = 1'b0;
        D_13  = 1'b1;
        set_a(3'd2);
        tick();
        chk("reset_mid_write", q, 8'h00);
        rst   = 1'b0;
        En_14 = 1'b1;
        tick();
        chk("reset_release", q, 8'h00);

        load(8'hA5);
        chk("load_a5", q, 8'hA5);
        for (int i = 0; i < 16; i++) begin
            D_13 = i[0];
            set_a(3'(i));
            tick();
            chk($sformatf("hold_%0d", i), q, 8'hA5);
        end

        load(8'hFF);
        chk("load_ff", q, 8'hFF);
        CLRn_15 = 1'b0;
        En_14   = 1'b0;
        set_a(3'd3);
        D_13 = 1'b1;
        tick();
        chk("demux_a3_d1", q, 8'h08);
        set_a(3'd6);
        tick();
        chk("demux_move_a6", q, 8'h40);
        D_13 = 1'b0;
        tick();
        chk("demux_d0", q, 8'h00);

        load(8'h5A);
        chk("load_5a", q, 8'h5A);
        CLRn_15 = 1'b0;
        En_14   = 1'b1;
        tick();
        chk("clear", q, 8'h00);

        CLRn_15 = 1'b1;
        En_14   = 1'b0;
        set_a(3'd4);
        D_13 = 1'b1;
        tick();
        D_13 = 1'b0;
        set_a(3'd1);
        tick();
        chk("write_keeps_prior", q, 8'h10);
        D_13 = 1'b1;
        set_a(3'd7);
        tick();
        chk("simul_d_addr", q, 8'h90);

`ifdef CHIPI74LS259_READBACK_EN
        for (int p = 0; p < 256; p++) begin
            load(8'(p));
            for (int r = 0; r < 8; r++) begin
                {RdA2, RdA1, RdA0} = 3'(r);
                #1 chk($sformatf("rd_%0h_%0d", p, r), {7'd0, Rd_Z}, {7'd0, p[r]});
            end
        end
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
